cmp_share_arbiter: RTL

- Shares one WIDTH-bit magnitude compare unit (eq/gt/lt) between N_REQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Single registered response stage carrying the result and the requester ID.
- Sits between client blocks issuing operand pairs and the unsigned comparator datapath; the compare logic is instantiated internally.

---
 rtl/cmp_share_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmp_share_arbiter
// Brief    : Round-robin arbiter sharing one unsigned eq/gt/lt comparator
//            between N_REQ requesters, with a single registered response.
//            Optional macro CMP_SHARE_STATS_EN adds saturating result counters.
// Revision : 1.0  initial release
// ============================================================================
module cmp_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic                       rsp_eq,
    output logic                       rsp_gt,
    output logic                       rsp_lt,
`ifdef CMP_SHARE_STATS_EN
    output logic [15:0]                cnt_eq,
    output logic [15:0]                cnt_gt,
    output logic [15:0]                cnt_lt,
`endif
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic             r_rsp_eq;
    logic             r_rsp_gt;
    logic             r_rsp_lt;

    logic             w_found;
    logic [ID_W-1:0]  w_grant;
    logic             w_can_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [ID_W-1:0]  w_next_ptr;

    // Rotating priority scan starting at r_rr_ptr; inner loop keeps indices constant.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int w_idx;
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && (w_idx == i) && req_valid[i]) begin
                    w_found = 1'b1;
                    w_grant = ID_W'(i);
                end
            end
        end
    end

    assign w_can_accept = !r_rsp_valid || rsp_ready;
    assign w_xfer       = w_found && w_can_accept && !rst;
    assign w_next_ptr   = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + ID_W'(1);

    always_comb begin
        w_a       = '0;
        w_b       = '0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_a          = req_a[i*WIDTH +: WIDTH];
                w_b          = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_eq    <= 1'b0;
            r_rsp_gt    <= 1'b0;
            r_rsp_lt    <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr    <= w_next_ptr;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_grant;
            r_rsp_eq    <= (w_a == w_b);
            r_rsp_gt    <= (w_a >  w_b);
            r_rsp_lt    <= (w_a <  w_b);
        end else if (r_rsp_valid && rsp_ready) begin
            // Drain only: payload fields keep their last values.
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_eq    = r_rsp_eq;
    assign rsp_gt    = r_rsp_gt;
    assign rsp_lt    = r_rsp_lt;
    assign busy      = r_rsp_valid || (|req_valid);

`ifdef CMP_SHARE_STATS_EN
    logic [15:0] r_cnt_eq;
    logic [15:0] r_cnt_gt;
    logic [15:0] r_cnt_lt;
    logic        w_rsp_hs;

    assign w_rsp_hs = r_rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_eq <= '0;
            r_cnt_gt <= '0;
            r_cnt_lt <= '0;
        end else if (w_rsp_hs) begin
            if (r_rsp_eq && (r_cnt_eq != 16'hFFFF)) r_cnt_eq <= r_cnt_eq + 16'd1;
            if (r_rsp_gt && (r_cnt_gt != 16'hFFFF)) r_cnt_gt <= r_cnt_gt + 16'd1;
            if (r_rsp_lt && (r_cnt_lt != 16'hFFFF)) r_cnt_lt <= r_cnt_lt + 16'd1;
        end
    end

    assign cnt_eq = r_cnt_eq;
    assign cnt_gt = r_cnt_gt;
    assign cnt_lt = r_cnt_lt;
`endif

endmodule
`default_nettype wire
